// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter frame controller:
// frame state encoding, parity mode constants and the default data width.
package uart_tx_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    // Parity mode of the upstream parity calculator. The frame controller only
    // forwards par_bit; these constants document what the calculator produces.
    localparam logic EVEN_PAR = 1'b0;
    localparam logic ODD_PAR  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    // Width of the data bit counter; never below one bit.
    function automatic int cnt_width(input int data_width);
        return (data_width > 1) ? $clog2(data_width) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit counter of the UART transmitter.
// load copies a new byte and clears the counter, shift moves the next data bit
// into position 0, advance steps the counter, done flags the last data bit.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  shift,
    input  logic                  advance,
    output logic                  ser_bit,
    output logic                  done
);

    localparam int                CNT_W    = cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;

    // Shift register and bit counter; load has priority over shift/advance.
    always_ff @(posedge CLK) begin
        // NOTE: the data register is reset too, so a frame aborted by RST
        // leaves no stale bits behind that could leak into a later frame.
        if (RST) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            bit_cnt   <= '0;
        end else begin
            if (shift) begin
                shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
            end
            // Saturate at the last index so the counter never wraps.
            if (advance && (bit_cnt != LAST_IDX)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
        end
    end

    assign ser_bit = shift_reg[0];
    assign done    = (bit_cnt == LAST_IDX);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmitter frame FSM: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit(s). One line bit per CLK cycle.
// TX_OUT and busy are registered from the next-state decision, so the bit
// on the line always belongs to the state currently held in the state register.
// Optional build macro: UART_TX_STOP2_EN -- two stop bits instead of one.
module uart_tx_frame_ctrl
    import uart_tx_pkg::*;
#(
    parameter int   DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  par_bit,
    output logic                  TX_OUT,
    output logic                  busy
);

    tx_state_t state;
    tx_state_t next_state;

    logic tx_next;
    logic busy_next;
    logic par_en_q;
    logic par_q;

    logic ser_load;
    logic ser_shift;
    logic ser_advance;
    logic ser_bit;
    logic ser_done;

`ifdef UART_TX_STOP2_EN
    // High while the second of the two stop bits is on the line.
    logic stop_cnt_q;

    // Stop bit index: set during the first stop bit, cleared otherwise.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= (state == STOP) && !stop_cnt_q;
        end
    end
`endif

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_serializer (
        .CLK       (CLK),
        .RST       (RST),
        .load      (ser_load),
        .load_data (P_DATA),
        .shift     (ser_shift),
        .advance   (ser_advance),
        .ser_bit   (ser_bit),
        .done      (ser_done)
    );

    // Next-state, next line level and serializer controls.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        next_state  = state;
        tx_next     = IDLE_LEVEL;
        busy_next   = 1'b1;
        ser_load    = 1'b0;
        ser_shift   = 1'b0;
        ser_advance = 1'b0;

        case (state)
            IDLE: begin
                if (DATA_VALID) begin
                    next_state = START;
                    tx_next    = ~IDLE_LEVEL;
                    ser_load   = 1'b1;
                end else begin
                    busy_next  = 1'b0;
                end
            end

            START: begin
                // Bit 0 goes on the line next; bring bit 1 into position.
                next_state = DATA;
                tx_next    = ser_bit;
                ser_shift  = 1'b1;
            end

            DATA: begin
                if (ser_done) begin
                    if (par_en_q) begin
                        next_state = PARITY;
                        tx_next    = par_q;
                    end else begin
                        next_state = STOP;
                    end
                end else begin
                    tx_next     = ser_bit;
                    ser_shift   = 1'b1;
                    ser_advance = 1'b1;
                end
            end

            PARITY: begin
                next_state = STOP;
            end

            STOP: begin
`ifdef UART_TX_STOP2_EN
                if (stop_cnt_q) begin
                    next_state = IDLE;
                    busy_next  = 1'b0;
                end
`else
                next_state = IDLE;
                busy_next  = 1'b0;
`endif
            end

            default: begin
                next_state = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State, registered outputs and the per-frame parity settings.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register here sees the pre-edge values of the others.
        if (RST) begin
            state    <= IDLE;
            TX_OUT   <= IDLE_LEVEL;
            busy     <= 1'b0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
        end else begin
            state  <= next_state;
            TX_OUT <= tx_next;
            busy   <= busy_next;
            if ((state == IDLE) && DATA_VALID) begin
                par_en_q <= PAR_EN;
            end
            // The parity calculator's registered output is valid in START only.
            if (state == START) begin
                par_q <= par_bit;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench for uart_tx_frame_ctrl (DATA_WIDTH=8, IDLE_LEVEL=1).
// Stimulus pushes hand-written line sequences, frame lengths and idle gaps;
// a monitor on the falling clock edge pops and compares them against TX_OUT/busy.
module tb_uart_tx_frame_ctrl;
    import uart_tx_pkg::*;

    localparam int DW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          par_bit;
    logic          TX_OUT;
    logic          busy;

    int   vectors = 0;
    int   errors  = 0;
    bit   mon_en  = 1'b0;

    logic exp_bits[$];
    int   exp_len[$];
    int   exp_gap[$];

    uart_tx_frame_ctrl #(
        .DATA_WIDTH (DW),
        .IDLE_LEVEL (1'b1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .par_bit    (par_bit),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Push one expected frame: seq[n-1] is the first bit on the line.
    // full=1 means the frame runs to its stop bit(s); gap=-1 means don't care.
    task automatic push_seq(input logic [15:0] seq, input int n, input int gap, input bit full);
        int len;
        len = n;
        for (int i = n - 1; i >= 0; i--) exp_bits.push_back(seq[i]);
`ifdef UART_TX_STOP2_EN
        if (full) begin
            exp_bits.push_back(1'b1);
            len++;
        end
`else
        if (full) len = n;
`endif
        exp_len.push_back(len);
        exp_gap.push_back(gap);
    endtask

    // Request one frame; after acceptance the inputs are scrambled to show
    // they are latched, and par_bit is flipped after its START sampling slot.
    // Returns one cycle into the first data bit.
    task automatic send(input logic [DW-1:0] d, input logic pen, input logic p);
        @(posedge CLK); #1;
        P_DATA     = d;
        PAR_EN     = pen;
        DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        P_DATA     = ~d;
        PAR_EN     = ~pen;
        par_bit    = p;
        @(posedge CLK); #1;
        par_bit    = ~p;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((busy || exp_bits.size() != 0 || exp_len.size() != 0) && n < 200);
        if (busy || exp_bits.size() != 0 || exp_len.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL wait_idle: timeout, busy=%b pending_bits=%0d", busy, exp_bits.size());
        end
    endtask

    task automatic wait_busy_low();
        int n;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (busy && n < 100);
        if (busy) begin
            vectors++;
            errors++;
            $display("FAIL wait_busy_low: busy stuck high");
        end
    endtask

    // Monitor: compare each busy cycle's line bit, each frame's busy length,
    // the idle gap before a frame, and the idle level between frames.
    initial begin : monitor
        int   run;
        int   idle_run;
        int   g;
        int   l;
        logic b;
        run      = 0;
        idle_run = 1000;
        forever begin
            @(negedge CLK);
            if (mon_en) begin
                if (busy === 1'b1) begin
                    if (run == 0 && exp_gap.size() != 0) begin
                        g = exp_gap.pop_front();
                        if (g >= 0) check("idle_gap", idle_run, g);
                    end
                    run++;
                    if (exp_bits.size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL tx_underflow: busy with no expected bit, TX_OUT=%b at %0t", TX_OUT, $time);
                    end else begin
                        b = exp_bits.pop_front();
                        check("tx_bit", TX_OUT, b);
                    end
                end else begin
                    if (run > 0) begin
                        if (exp_len.size() == 0) begin
                            vectors++;
                            errors++;
                            $display("FAIL frame_len: unexpected frame of %0d cycles", run);
                        end else begin
                            l = exp_len.pop_front();
                            check("frame_len", run, l);
                        end
                        run      = 0;
                        idle_run = 0;
                    end
                    idle_run++;
                    check("idle_level", {TX_OUT, busy}, 2'b10);
                end
            end
        end
    end

    initial begin : stimulus
        RST        = 1'b1;
        P_DATA     = '0;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        par_bit    = 1'b0;

        // Reset held for two cycles: line idle, not busy.
        repeat (2) begin
            @(posedge CLK);
            @(negedge CLK);
            check("reset_tx", TX_OUT, 1'b1);
            check("reset_busy", busy, 1'b0);
        end
        RST    = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge CLK);

        // 0xA5, even parity (par_bit=0).
        push_seq(16'b01010010101, 11, -1, 1'b1);
        send(8'hA5, 1'b1, 1'b0);
        wait_idle();

        // 0x01, odd parity (par_bit=0).
        push_seq(16'b01000000001, 11, -1, 1'b1);
        send(8'h01, 1'b1, 1'b0);
        wait_idle();

        // 0x01, even parity (par_bit=1).
        push_seq(16'b01000000011, 11, -1, 1'b1);
        send(8'h01, 1'b1, 1'b1);
        wait_idle();

        // Back-to-back without parity, DATA_VALID held high throughout.
        push_seq(16'b0111111111, 10, -1, 1'b1);
        push_seq(16'b0000000001, 10, 1, 1'b1);
        @(posedge CLK); #1;
        P_DATA     = 8'hFF;
        PAR_EN     = 1'b0;
        DATA_VALID = 1'b1;
        @(posedge CLK); #1;
        P_DATA     = 8'h00;
        wait_busy_low();
        @(posedge CLK); #1;
        DATA_VALID = 1'b0;
        wait_idle();

        // Reset during the 4th data bit of 0x3C: frame cut after start+4 bits.
        push_seq(16'b00011, 5, -1, 1'b0);
        send(8'h3C, 1'b1, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // Clean full frame after the abort: 0x3C, even parity (par_bit=0).
        push_seq(16'b00011110001, 11, -1, 1'b1);
        send(8'h3C, 1'b1, 1'b0);
        wait_idle();

        repeat (5) @(negedge CLK);
        check("pending_bits", exp_bits.size(), 0);
        check("pending_frames", exp_len.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
